// File: rtl/header_footer_gen_param_if.sv
// Stream and FIFO-write bundle between trigger logic, the header/footer generator
// and the per-channel ADC/HF FIFOs.
interface header_footer_gen_param_if #(parameter int DW = 128);
   logic [DW+65:0]  S_AXIS_TDATA;
   logic            S_AXIS_TVALID;
   logic            S_AXIS_TREADY;
   logic [DW-1:0]   ADC_DATA;
   logic            ADC_VALID;
   logic            ADC_FIFO_ALMOST_FULL;
   logic [2*DW-1:0] HEADER_FOOTER_DATA;
   logic            HEADER_FOOTER_VALID;
   logic            HF_FIFO_ALMOST_FULL;

   modport master (
      output S_AXIS_TDATA, S_AXIS_TVALID, ADC_FIFO_ALMOST_FULL, HF_FIFO_ALMOST_FULL,
      input  S_AXIS_TREADY, ADC_DATA, ADC_VALID, HEADER_FOOTER_DATA, HEADER_FOOTER_VALID
   );
   modport slave (
      input  S_AXIS_TDATA, S_AXIS_TVALID, ADC_FIFO_ALMOST_FULL, HF_FIFO_ALMOST_FULL,
      output S_AXIS_TREADY, ADC_DATA, ADC_VALID, HEADER_FOOTER_DATA, HEADER_FOOTER_VALID
   );
endinterface

// File: rtl/header_footer_gen_param.sv
// Per-channel header/footer generator: re-times trigger-gated ADC beats and emits one
// header+footer pair per frame. Define HF_PEAK_EN to carry the frame peak sample in the header.
module header_footer_gen_param #(
   parameter int CHANNEL_ID      = 0,
   parameter int SAMPLE_WIDTH    = 16,
   parameter int SAMPLES_PER_CLK = 8,
   parameter int CHARGE_WIDTH    = 24,
   parameter int DEFAULT_MAX_LEN = 100
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        SET_CONFIG,
   input  logic [11:0] MAX_TRIGGER_LENGTH,
   header_footer_gen_param_if.slave bus
);
   localparam int DW   = SAMPLE_WIDTH * SAMPLES_PER_CLK;
   localparam int BSW  = SAMPLE_WIDTH + $clog2(SAMPLES_PER_CLK);
   localparam int SUMW = ((CHARGE_WIDTH > BSW) ? CHARGE_WIDTH : BSW) + 1;
   localparam logic [SUMW-1:0] SAT_MAX = {{(SUMW-CHARGE_WIDTH){1'b0}}, {CHARGE_WIDTH{1'b1}}};

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DROP = 2'd2} state_t;
   state_t state_q, state_d;

   logic [SAMPLES_PER_CLK-1:0][SAMPLE_WIDTH-1:0] lanes, lane_v;
   logic [1:0]  in_tt;
   logic [47:0] in_ts;
   logic [15:0] in_cfg;
   logic        tvalid, take, wr, ovf, split, new_frame, end_close, frame_hg;

   logic [11:0]             max_len_q, max_len_d, len_q, len_d, base_len, len_inc, eff_max;
   logic [15:0]             oid_q, oid_d, cfg_q, cfg_d;
   logic [1:0]              tt_q, tt_d;
   logic [47:0]             ts_q, ts_d;
   logic [CHARGE_WIDTH-1:0] sum_q, sum_d, base_sum, sat_sum;
   logic [SUMW-1:0]         beat_sum, tot;
   logic [DW-1:0]           adc_data_q, adc_data_d, hdr, ftr;
   logic first_q, first_d, open_q, open_d, adc_vld_q;
   logic hf_pulse_q, hf_cont_q, hf_trunc_q, hf_vld, cont, trunc;
   logic [1:0] fstate;
`ifdef HF_PEAK_EN
   logic [SAMPLE_WIDTH-1:0] peak_q, peak_d, base_peak, beat_peak;
`endif

   assign tvalid = bus.S_AXIS_TVALID;
   assign lanes  = bus.S_AXIS_TDATA[DW+65:66];
   assign in_tt  = bus.S_AXIS_TDATA[65:64];
   assign in_ts  = bus.S_AXIS_TDATA[63:16];
   assign in_cfg = bus.S_AXIS_TDATA[15:0];

   // Either FIFO near full turns the beat into an overflow; the HF slot is reserved for its header.
   assign take      = tvalid && (state_q != DROP);
   assign ovf       = take && (bus.ADC_FIFO_ALMOST_FULL || bus.HF_FIFO_ALMOST_FULL);
   assign wr        = take && !ovf;
   assign new_frame = take && ((state_q == IDLE) || !open_q);
   assign end_close = (state_q == RUN) && open_q && !tvalid;
   assign frame_hg  = new_frame ? in_tt[1] : tt_q[1];
   assign eff_max   = (max_len_q == 12'd0) ? 12'd1 : max_len_q;
   assign base_len  = new_frame ? 12'd0 : len_q;
   assign len_inc   = base_len + 12'd1;
   assign split     = wr && (len_inc == eff_max);
   assign base_sum  = new_frame ? '0 : sum_q;

   for (genvar g = 0; g < SAMPLES_PER_CLK; g++) begin : g_lane
      assign lane_v[g] = (frame_hg || g == 0) ? lanes[g] : '0;
   end

   always_comb begin
      beat_sum = '0;
      for (int i = 0; i < SAMPLES_PER_CLK; i++) beat_sum = beat_sum + SUMW'(lane_v[i]);
      tot     = SUMW'(base_sum) + beat_sum;
      sat_sum = (tot > SAT_MAX) ? {CHARGE_WIDTH{1'b1}} : tot[CHARGE_WIDTH-1:0];
   end

`ifdef HF_PEAK_EN
   always_comb begin
      beat_peak = '0;
      for (int i = 0; i < SAMPLES_PER_CLK; i++)
         if (lane_v[i] > beat_peak) beat_peak = lane_v[i];
      base_peak = new_frame ? '0 : peak_q;
      peak_d    = peak_q;
      if (take) peak_d = (wr && beat_peak > base_peak) ? beat_peak : base_peak;
   end
`endif

   always_comb begin
      max_len_d  = max_len_q;
      oid_d      = oid_q;
      tt_d       = tt_q;
      ts_d       = ts_q;
      cfg_d      = cfg_q;
      first_d    = first_q;
      len_d      = len_q;
      sum_d      = sum_q;
      open_d     = open_q;
      adc_data_d = adc_data_q;
      if (state_q == IDLE && SET_CONFIG) max_len_d = MAX_TRIGGER_LENGTH;
      if (state_q == IDLE && tvalid)     oid_d = oid_q + 16'd1;
      if (new_frame) begin
         tt_d    = in_tt;
         ts_d    = in_ts;
         cfg_d   = in_cfg;
         first_d = (state_q == IDLE);
      end
      if (take) begin
         len_d  = wr ? len_inc : base_len;
         sum_d  = wr ? sat_sum : base_sum;
         open_d = wr && !split;
      end else if (end_close) begin
         open_d = 1'b0;
      end
      if (wr) adc_data_d = lanes;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (tvalid) state_d = ovf ? DROP : RUN;
         RUN:     if (ovf) state_d = DROP; else if (!tvalid) state_d = IDLE;
         DROP:    if (!tvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         max_len_q  <= 12'(DEFAULT_MAX_LEN);
         oid_q      <= 16'hFFFF;
         tt_q       <= '0;
         ts_q       <= '0;
         cfg_q      <= '0;
         first_q    <= 1'b0;
         len_q      <= '0;
         sum_q      <= '0;
         open_q     <= 1'b0;
         adc_data_q <= '0;
         adc_vld_q  <= 1'b0;
         hf_pulse_q <= 1'b0;
         hf_cont_q  <= 1'b0;
         hf_trunc_q <= 1'b0;
`ifdef HF_PEAK_EN
         peak_q     <= '0;
`endif
      end else begin
         max_len_q  <= max_len_d;
         oid_q      <= oid_d;
         tt_q       <= tt_d;
         ts_q       <= ts_d;
         cfg_q      <= cfg_d;
         first_q    <= first_d;
         len_q      <= len_d;
         sum_q      <= sum_d;
         open_q     <= open_d;
         adc_data_q <= adc_data_d;
         adc_vld_q  <= wr;
         hf_pulse_q <= split || ovf;
         hf_cont_q  <= split;
         hf_trunc_q <= ovf;
`ifdef HF_PEAK_EN
         peak_q     <= peak_d;
`endif
      end
   end

   // End-of-trigger close is seen combinationally so it lines up with the last beat's ADC_VALID.
   always_comb begin
      hf_vld = hf_pulse_q || end_close;
      cont   = hf_pulse_q && hf_cont_q;
      trunc  = hf_pulse_q && hf_trunc_q;
      fstate = trunc ? 2'b10 : (first_q ? 2'b01 : 2'b11);
      hdr = '0;
      hdr[DW-1 -: 8]   = 8'hAA;
      hdr[DW-9 -: 8]   = 8'(CHANNEL_ID);
      hdr[DW-17 -: 12] = len_q;
      hdr[DW-29 -: 4]  = {1'b0, fstate, cont};
      hdr[DW-33 -: 2]  = tt_q;
      hdr[DW-35 -: 24] = ts_q[47:24];
`ifdef HF_PEAK_EN
      hdr[DW-59 -: 16] = 16'(peak_q);
`endif
      hdr[16 +: CHARGE_WIDTH] = sum_q;
      hdr[15:0]        = cfg_q;
      ftr = '0;
      ftr[47:24] = ts_q[23:0];
      ftr[23:8]  = oid_q;
      ftr[7:0]   = 8'h55;
   end

   assign bus.S_AXIS_TREADY       = 1'b1;
   assign bus.ADC_DATA            = adc_data_q;
   assign bus.ADC_VALID           = adc_vld_q;
   assign bus.HEADER_FOOTER_VALID = hf_vld;
   assign bus.HEADER_FOOTER_DATA  = hf_vld ? {hdr, ftr} : '0;
endmodule
